quad_updown_gen: RTL
====================

# quad_updown_gen

Quadrature-to-pulse front end that converts two raw mechanical/optical encoder channels (A, B) into the single-cycle `up`/`down` strobes consumed by the team's up/down counters. It synchronizes and debounces both channels, tracks the 2-bit Gray-code phase in a state machine, and emits one strobe per legal phase step (x4 decoding). Illegal double-steps are flagged instead of counted. It sits between the board pins and any `contador_*` up/down counter.

## Interface
- `DEB` — default 4 — consecutive stable samples required before a channel change is accepted (range 1..255)
- `clk` — in — 1 — system clock; all state on rising edge
- `rst` — in — 1 — asynchronous, active-low reset; one clock domain
- `en` — in — 1 — strobe enable; when 0, phase still tracked, no `up`/`down`/`err`
- `a_in` — in — 1 — raw channel A (asynchronous pin)
- `b_in` — in — 1 — raw channel B (asynchronous pin)
- `up` — out — 1 — one-cycle strobe, one legal clockwise step
- `down` — out — 1 — one-cycle strobe, one legal counter-clockwise step
- `err` — out — 1 — one-cycle strobe, illegal transition (both channels changed)
- `phase` — out — 2 — current debounced {A,B}

## Operation
- Synchronizer: two flops per channel (`s1`, `s2`), reset 0.
- Debounce, per channel: counter `cnt` (8 bits) and filtered bit `f`, reset 0.
  - `s2 == f`: `cnt <= 0`.
  - `s2 != f` and `cnt == DEB-1`: `f <= s2`, `cnt <= 0`.
  - otherwise `cnt <= cnt+1`.
  - A glitch shorter than DEB samples never reaches `f`.
- Phase FSM: register `prev` = last {fA,fB}, reset 00. Every cycle `prev <= {fA,fB}`. `phase` = {fA,fB}.
  - Clockwise sequence 00→01→11→10→00: `up` pulse.
  - Counter-clockwise 00→10→11→01→00: `down` pulse.
  - No change: no pulse.
  - Both bits changed (00↔11, 01↔10): `err` pulse; no `up`/`down`; `prev` still updates.
- Startup blanking: counter `wake` reset 0, counts to DEB+3 and saturates. `up`/`down`/`err` are forced 0 until saturation. This absorbs the pin state present at reset release, e.g. pins at 11 produce no spurious `err`.
- `en = 0`: strobes forced 0. FSM and filters keep running, so re-enabling never produces a catch-up pulse.
- `up`, `down` and `err` are mutually exclusive.

## Timing
- Reset (`rst` low, asynchronously): `up = down = err = 0`, `phase = 00`, all internal state 0.
- Pin-to-strobe latency, pin stable before capturing edge k:
  - `s1` at k, `s2` at k+1.
  - `f` updates at edge k+1+DEB.
  - Strobe registered at edge k+2+DEB and high for exactly one cycle.
  - DEB = 4: strobe 6 cycles after the capture edge.
- Strobes are registered outputs, with no combinational path from pins.
- Maximum accepted step rate: one phase step per DEB+1 cycles per channel. Faster inputs are filtered, not queued.
- Simultaneous A and B edges at the pin: both filters accept on the same edge, which produces `err`. If they are accepted on different edges, two legal steps result.
- `rst` asserted mid-debounce: partial counts are discarded. After release, blanking runs again for DEB+3 cycles.

## Test plan
- Reset, then pins held 11 for 20 cycles (DEB = 4): `phase` = 11 by cycle 7, and `up`/`down`/`err` stay 0 throughout.
- Four clockwise steps 00→01→11→10→00, 10 cycles apart, `en = 1`: exactly 4 `up` pulses, each 6 cycles after its pin edge, `down = err = 0`.
- Four counter-clockwise steps, same spacing: exactly 4 `down` pulses, 0 `up`. Chaining into a 4-bit counter from 0 gives 15, 14, 13, 12 (wrap-around).
- 3-cycle glitch on A (shorter than DEB = 4), otherwise idle: no strobe, `phase` unchanged.
- A and B toggled on the same cycle, 00→11: one `err` pulse, no `up`/`down`, `phase` = 11.
- `en = 0` during two clockwise steps, then `en = 1`: no pulses, `phase` correct, and the next clockwise step gives exactly 1 `up`. Asserting `rst` mid-debounce clears all outputs immediately.

Source files
------------

// File: rtl/quad_updown_gen.sv
// Quadrature front end: synchronizes and debounces encoder channels A/B, tracks
// the Gray-code phase and emits one-cycle up/down strobes (x4) or err on double steps.
module quad_updown_gen #(
  parameter int DEB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a_in,
  input  logic       b_in,
  output logic       up,
  output logic       down,
  output logic       err,
  output logic [1:0] phase
);

  localparam logic [7:0] DEB_M1   = 8'(DEB - 1);
  localparam logic [8:0] WAKE_MAX = 9'(DEB + 3);

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  // Bit 1 carries channel A, bit 0 carries channel B.
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] f;
  logic [7:0] cnt [2];
  logic [8:0] wake;
  phase_t     prev;
  phase_t     cur;

  logic       step_cw;
  logic       step_ccw;
  logic       step_bad;
  logic       live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a_in, b_in};
      s2 <= s1;
    end
  end

  // A change is accepted only after DEB consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f      <= 2'b00;
      cnt[0] <= 8'd0;
      cnt[1] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) begin
          cnt[i] <= 8'd0;
        end else if (cnt[i] == DEB_M1) begin
          f[i]   <= s2[i];
          cnt[i] <= 8'd0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Blanking window swallows whatever the pins showed when reset released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wake <= 9'd0;
    end else if (wake != WAKE_MAX) begin
      wake <= wake + 9'd1;
    end
  end

  always_comb begin
    cur      = phase_t'(f);
    live     = en && (wake == WAKE_MAX);
    step_cw  = ((prev == PH_00) && (cur == PH_01)) ||
               ((prev == PH_01) && (cur == PH_11)) ||
               ((prev == PH_11) && (cur == PH_10)) ||
               ((prev == PH_10) && (cur == PH_00));
    step_ccw = ((prev == PH_00) && (cur == PH_10)) ||
               ((prev == PH_10) && (cur == PH_11)) ||
               ((prev == PH_11) && (cur == PH_01)) ||
               ((prev == PH_01) && (cur == PH_00));
    step_bad = ((prev ^ cur) == 2'b11);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= PH_00;
      up   <= 1'b0;
      down <= 1'b0;
      err  <= 1'b0;
    end else begin
      prev <= cur;
      up   <= live && step_cw;
      down <= live && step_ccw;
      err  <= live && step_bad;
    end
  end

  assign phase = f;

endmodule
